// File: rtl/led_band_pkg.sv
// Shared constants and state encoding for the LED band frame writer.
package led_band_pkg;

   localparam int FRAME_WORDS = 864;
   localparam int BANK_OFFSET = 1024;
   localparam int LANES       = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WAIT_SWAP
   } writer_state_t;

endpackage

// File: rtl/led_band_writer.sv
// Packs 32-bit pixel beats into 128-bit memory words and double-buffers two
// frame banks, handing a finished bank to the LED reader on swap_ack.
module led_band_writer
   import led_band_pkg::*;
#(
   parameter int W_ADDR_WIDTH = 11,
   parameter int W_DATA_WIDTH = 128,
   parameter int IN_WIDTH     = 32,
   parameter int FRAME_WORDS  = led_band_pkg::FRAME_WORDS,
   parameter int BANK_OFFSET  = led_band_pkg::BANK_OFFSET
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IN_WIDTH-1:0]     in_data,
   input  logic                    in_valid,
   input  logic                    in_sof,
   output logic                    in_ready,
   output logic [W_ADDR_WIDTH-1:0] w_addr,
   output logic [W_DATA_WIDTH-1:0] w_data,
   output logic                    w_enable,
   input  logic                    swap_ack,
   output logic                    frame_ready,
   output logic                    disp_bank,
   output logic                    err_sof
);

   localparam int WORD_W     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int LANE_IDX_W = $clog2(LANES);

   if ((W_DATA_WIDTH != LANES * IN_WIDTH) || (FRAME_WORDS > BANK_OFFSET) ||
       (2 * BANK_OFFSET > (2 ** W_ADDR_WIDTH))) begin : g_param_check
      $error("led_band_writer: illegal width or bank parameters");
   end

   writer_state_t           r_state;
   logic                    r_alive;
   logic                    r_wr_bank;
   logic                    r_disp_bank;
   logic [LANE_IDX_W-1:0]   r_lane_idx;
   logic [WORD_W-1:0]       r_word;
   logic [W_ADDR_WIDTH-1:0] r_w_addr;
   logic [W_DATA_WIDTH-1:0] r_w_data;
   logic                    r_w_enable;
   logic                    r_frame_ready;
   logic                    r_err_sof;

   // Only the first LANES-1 beats need storage; the last beat joins the word directly.
   logic [IN_WIDTH-1:0]     r_lane [LANES-1];

   logic                    w_ready;
   logic                    w_accept;
   logic                    w_last_lane;
   logic                    w_last_word;
   logic [W_ADDR_WIDTH-1:0] w_bank_base;
   logic [W_ADDR_WIDTH-1:0] w_word_addr;
   logic [W_DATA_WIDTH-1:0] w_packed;

   assign w_ready     = r_alive && (r_state != WAIT_SWAP);
   assign w_accept    = in_valid && w_ready;
   assign w_last_lane = (r_lane_idx == LANE_IDX_W'(LANES - 1));
   assign w_last_word = (r_word == WORD_W'(FRAME_WORDS - 1));
   assign w_bank_base = r_wr_bank ? W_ADDR_WIDTH'(BANK_OFFSET) : '0;
   assign w_word_addr = w_bank_base + W_ADDR_WIDTH'(r_word);

   always_comb begin
      w_packed = '0;
      for (int i = 0; i < LANES - 1; i++) begin
         w_packed[i*IN_WIDTH +: IN_WIDTH] = r_lane[i];
      end
      w_packed[(LANES-1)*IN_WIDTH +: IN_WIDTH] = in_data;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         if (in_sof) begin
            r_lane[0] <= in_data;
         end else if ((r_state == FILL) && !w_last_lane) begin
            r_lane[r_lane_idx] <= in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_alive       <= 1'b0;
         r_wr_bank     <= 1'b1;
         r_disp_bank   <= 1'b0;
         r_lane_idx    <= '0;
         r_word        <= '0;
         r_w_addr      <= '0;
         r_w_data      <= '0;
         r_w_enable    <= 1'b0;
         r_frame_ready <= 1'b0;
         r_err_sof     <= 1'b0;
      end else begin
         r_alive    <= 1'b1;
         r_w_enable <= 1'b0;
         r_err_sof  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept && in_sof) begin
                  r_lane_idx <= LANE_IDX_W'(1);
                  r_word     <= '0;
                  r_state    <= FILL;
               end
            end
            FILL: begin
               if (w_accept) begin
                  if (in_sof) begin
                     // Restart in place: the partial word is simply overwritten.
                     r_err_sof  <= 1'b1;
                     r_lane_idx <= LANE_IDX_W'(1);
                     r_word     <= '0;
                  end else if (w_last_lane) begin
                     r_w_enable <= 1'b1;
                     r_w_data   <= w_packed;
                     r_w_addr   <= w_word_addr;
                     r_lane_idx <= '0;
                     if (w_last_word) begin
                        r_word        <= '0;
                        r_state       <= WAIT_SWAP;
                        r_frame_ready <= 1'b1;
                     end else begin
                        r_word <= r_word + WORD_W'(1);
                     end
                  end else begin
                     r_lane_idx <= r_lane_idx + LANE_IDX_W'(1);
                  end
               end
            end
            WAIT_SWAP: begin
               if (swap_ack) begin
                  r_disp_bank   <= r_wr_bank;
                  r_wr_bank     <= ~r_wr_bank;
                  r_frame_ready <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = w_ready;
   assign w_addr      = r_w_addr;
   assign w_data      = r_w_data;
   assign w_enable    = r_w_enable;
   assign frame_ready = r_frame_ready;
   assign disp_bank   = r_disp_bank;
   assign err_sof     = r_err_sof;

endmodule

// File: tb/tb_led_band_writer.sv
// Randomized bench for led_band_writer against a beat-queue frame model.
module tb_led_band_writer;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_sof;
   logic         in_ready;
   logic [10:0]  w_addr;
   logic [127:0] w_data;
   logic         w_enable;
   logic         swap_ack;
   logic         frame_ready;
   logic         disp_bank;
   logic         err_sof;

   led_band_writer dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .in_ready    (in_ready),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .w_enable    (w_enable),
      .swap_ack    (swap_ack),
      .frame_ready (frame_ready),
      .disp_bank   (disp_bank),
      .err_sof     (err_sof)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: a frame is a growing list of beats; every fourth beat
   // forms one word landing at bank*1024 + word index.
   bit           m_alive, m_wait, m_infill, m_bank, m_disp, m_frame_ready;
   bit           m_wen, m_err;
   int           m_word;
   logic [31:0]  m_lanes[$];
   logic [10:0]  m_waddr;
   logic [127:0] m_wdata;

   int           n_writes = 0;
   int           n_err    = 0;
   logic [10:0]  last_waddr;
   logic [127:0] last_wdata;
   logic [7:0]   mem [0:32767];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return m_alive && !m_wait;
   endfunction

   task automatic model_reset();
      m_alive = 0; m_wait = 0; m_infill = 0; m_bank = 1; m_disp = 0;
      m_frame_ready = 0; m_wen = 0; m_err = 0; m_word = 0;
      m_lanes.delete();
      m_waddr = '0; m_wdata = '0;
   endtask

   task automatic model_step();
      m_wen = 0;
      m_err = 0;
      if (rst) begin
         model_reset();
      end else begin
         if (in_valid && m_ready()) begin
            if (in_sof) begin
               if (m_infill) m_err = 1;
               m_lanes.delete();
               m_lanes.push_back(in_data);
               m_word   = 0;
               m_infill = 1;
            end else if (m_infill) begin
               m_lanes.push_back(in_data);
               if (m_lanes.size() == 4) begin
                  m_wen   = 1;
                  m_waddr = 11'(int'(m_bank) * 1024 + m_word);
                  m_wdata = {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]};
                  m_lanes.delete();
                  m_word++;
                  if (m_word == 864) begin
                     m_wait        = 1;
                     m_infill      = 0;
                     m_frame_ready = 1;
                  end
               end
            end
         end
         if (m_wait && swap_ack) begin
            m_disp        = m_bank;
            m_bank        = !m_bank;
            m_frame_ready = 0;
            m_wait        = 0;
         end
         m_alive = 1;
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", in_ready, m_ready());
      chk("w_enable", w_enable, m_wen);
      chk("w_addr", w_addr, m_waddr);
      chk("w_data", w_data, m_wdata);
      chk("frame_ready", frame_ready, m_frame_ready);
      chk("disp_bank", disp_bank, m_disp);
      chk("err_sof", err_sof, m_err);
      if (w_enable === 1'b1) begin
         n_writes++;
         last_waddr = w_addr;
         last_wdata = w_data;
         for (int i = 0; i < 16; i++) mem[int'(w_addr) * 16 + i] = w_data[i*8 +: 8];
      end
      if (err_sof === 1'b1) n_err++;
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic s, input logic a);
      in_valid = v; in_data = d; in_sof = s; swap_ack = a;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send_beat(input logic [31:0] d, input logic s, input bit rnd);
      int  guard;
      bit  done;
      logic v;
      guard = 0;
      done  = 0;
      while (!done) begin
         v     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         done  = v && m_ready();
         step(v, d, s, 1'b0);
         guard++;
         if (!done && guard > 64) begin
            chk("beat_timeout", 1'b0, 1'b1);
            done = 1;
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, e0;
      rst = 1; in_valid = 0; in_data = '0; in_sof = 0; swap_ack = 0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b1, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_disp", disp_bank, 1'b0);
      rst = 0;
      step(1'b0, '0, 1'b0, 1'b0);
      chk("alive_in_ready", in_ready, 1'b1);

      // First frame into bank 1, starting with the known byte ramp.
      send_beat(32'h03020100, 1'b1, 1'b0);
      send_beat(32'h07060504, 1'b0, 1'b0);
      send_beat(32'h0B0A0908, 1'b0, 1'b0);
      chk("pre_write_count", n_writes, 0);
      send_beat(32'h0F0E0D0C, 1'b0, 1'b0);
      chk("first_count", n_writes, 1);
      chk("first_addr", last_waddr, 11'd1024);
      chk("first_data", last_wdata, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      chk("mem_byte", mem[16384 + 5], 8'h05);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("single_pulse", n_writes, 1);
      for (int i = 4; i < 3456; i++) send_beat($urandom, 1'b0, 1'b1);
      chk("frame1_writes", n_writes, 864);
      chk("frame1_last_addr", last_waddr, 11'd1887);
      chk("frame1_ready", frame_ready, 1'b1);
      chk("frame1_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, 1'b0);
      chk("wait_no_writes", n_writes, 864);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("swap1_disp", disp_bank, 1'b1);
      chk("swap1_ready", frame_ready, 1'b0);

      // Second frame into bank 0: idle drops, an aborted frame, then a restart.
      w0 = n_writes;
      e0 = n_err;
      for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'b1);
      chk("idle_drop", n_writes - w0, 0);
      send_beat($urandom, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'b1);
      send_beat($urandom, 1'b1, 1'b1);
      chk("err_sof_pulse", n_err - e0, 1);
      chk("abort_writes", n_writes - w0, 1);
      chk("abort_addr", last_waddr, 11'd0);
      for (int i = 1; i < 3456; i++) begin
         send_beat($urandom, 1'b0, 1'b1);
         if (i == 101) begin
            step(1'b0, '0, 1'b0, 1'b1);
            chk("ack_in_fill", disp_bank, 1'b1);
         end
      end
      chk("frame2_writes", n_writes - w0, 865);
      chk("frame2_last_addr", last_waddr, 11'd863);
      chk("frame2_err_total", n_err - e0, 1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("swap2_disp", disp_bank, 1'b0);

      // Third frame back into bank 1 at full rate.
      w0 = n_writes;
      send_beat($urandom, 1'b1, 1'b0);
      for (int i = 1; i < 3456; i++) send_beat($urandom, 1'b0, 1'b0);
      chk("frame3_writes", n_writes - w0, 864);
      chk("frame3_last_addr", last_waddr, 11'd1887);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("swap3_disp", disp_bank, 1'b1);

      // Reset lands on beat 2 of word 10 of a fourth frame.
      w0 = n_writes;
      send_beat($urandom, 1'b1, 1'b1);
      for (int i = 1; i < 42; i++) send_beat($urandom, 1'b0, 1'b1);
      chk("pre_rst_writes", n_writes - w0, 10);
      rst = 1;
      step(1'b1, $urandom, 1'b0, 1'b0);
      chk("rst_mid_writes", n_writes - w0, 10);
      chk("rst_mid_wen", w_enable, 1'b0);
      chk("rst_mid_ready", frame_ready, 1'b0);
      chk("rst_mid_disp", disp_bank, 1'b0);
      rst = 0;
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
      chk("post_rst_writes", n_writes - w0, 10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
